digit_scan_sequencer: RTL

Upstream feeder for the template-matching correlator in the digit-recognition datapath. On a start pulse it walks the stored input image once per reference digit. It fetches each pixel and the matching template pixel from synchronous memories and streams them to the correlator as `current`/`reference` with `temp`=1. After each digit's pixels it emits one `temp`=0 compare cycle carrying that digit's `index`, so the correlator's max/argmax logic sees every digit exactly once per scan.

---
 rtl/digit_pkg.sv | 24 ++
 rtl/digit_scan_addr_gen.sv | 59 +++++
 rtl/digit_scan_sequencer.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/digit_pkg.sv
// Shared definitions for the digit-recognition datapath: pixel/index widths,
// default image and template dimensions, and the scan sequencer state enum.
// The binarize helper is only referenced when DIGIT_SEQ_BINARIZE_EN is defined.
package digit_pkg;

    localparam int PIX_W              = 8;
    localparam int IDX_W              = 4;
    localparam int PIXELS_DEFAULT     = 64;
    localparam int NUM_DIGITS_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } scan_state_t;

    // Full-scale white for pixels at or above the threshold, black otherwise.
    function automatic logic [PIX_W-1:0] binarize(input logic [PIX_W-1:0] value,
                                                  input logic [PIX_W-1:0] thresh);
        return (value >= thresh) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};
    endfunction

endpackage

// File: rtl/digit_scan_addr_gen.sv
// Address generation for the digit scan: pixel counter, digit counter and a
// running template address that simply counts up across all digits, so the
// template ROM address digit*PIXELS + pixel is produced without a multiplier.
module digit_scan_addr_gen
    import digit_pkg::*;
#(
    parameter int PIXELS     = PIXELS_DEFAULT,
    parameter int NUM_DIGITS = NUM_DIGITS_DEFAULT,
    localparam int PIX_AW    = $clog2(PIXELS),
    localparam int REF_AW    = $clog2(NUM_DIGITS * PIXELS)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              advance,
    input  logic              compare,
    output logic [PIX_AW-1:0] pixel,
    output logic [IDX_W-1:0]  digit,
    output logic [REF_AW-1:0] ref_addr,
    output logic              last_pixel,
    output logic              last_digit
);

    localparam logic [PIX_AW-1:0] LAST_PIXEL = PIX_AW'(PIXELS - 1);
    localparam logic [IDX_W-1:0]  LAST_DIGIT = IDX_W'(NUM_DIGITS - 1);

    logic [PIX_AW-1:0] pixel_q;
    logic [IDX_W-1:0]  digit_q;
    logic [REF_AW-1:0] ref_q;

    // Counters: cleared on an accepted start, stepped per issue, and the pixel
    // counter rewound on the compare cycle while the digit moves on.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pixel_q <= '0;
            digit_q <= '0;
            ref_q   <= '0;
        end else if (clear) begin
            pixel_q <= '0;
            digit_q <= '0;
            ref_q   <= '0;
        end else if (advance) begin
            pixel_q <= pixel_q + 1'b1;
            ref_q   <= ref_q + 1'b1;
        end else if (compare) begin
            pixel_q <= '0;
            if (digit_q != LAST_DIGIT) begin
                digit_q <= digit_q + 1'b1;
            end
        end
    end

    assign pixel      = pixel_q;
    assign digit      = digit_q;
    assign ref_addr   = ref_q;
    assign last_pixel = (pixel_q == LAST_PIXEL);
    assign last_digit = (digit_q == LAST_DIGIT);

endmodule

// File: rtl/digit_scan_sequencer.sv
// Digit scan sequencer: walks the stored image once per reference template,
// streaming image/template pixel pairs to the correlator (temp=1) followed by
// one compare cycle (temp=0) per digit carrying that digit's index.
// Addresses are issued straight from the counters; temp, index and the data
// select are registered one cycle to line up with the 1-cycle memory reads.
// Optional build macro: DIGIT_SEQ_BINARIZE_EN (threshold the image pixel).
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start; busy low, index holds last digit
// ACCUM   | issue one image/template address pair per cycle
// COMPARE | one cycle with no issue; rewind pixel, advance digit
// DONE    | last compare is being presented; done pulses next cycle
module digit_scan_sequencer
    import digit_pkg::*;
#(
    parameter int               PIXELS     = PIXELS_DEFAULT,
    parameter int               NUM_DIGITS = NUM_DIGITS_DEFAULT,
    parameter logic [PIX_W-1:0] THRESH     = 8'd128,
    localparam int              PIX_AW     = $clog2(PIXELS),
    localparam int              REF_AW     = $clog2(NUM_DIGITS * PIXELS)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [PIX_AW-1:0] img_addr,
    input  logic [PIX_W-1:0]  img_data,
    output logic [REF_AW-1:0] ref_addr,
    input  logic [PIX_W-1:0]  ref_data,
    output logic [PIX_W-1:0]  current,
    output logic [PIX_W-1:0]  reference,
    output logic              temp,
    output logic [IDX_W-1:0]  index
);

    scan_state_t state_q;
    scan_state_t state_d;

    logic              clear;
    logic              advance;
    logic              compare;
    logic [PIX_AW-1:0] pixel;
    logic [IDX_W-1:0]  digit;
    logic              last_pixel;
    logic              last_digit;

    logic              temp_q;
    logic              done_q;
    logic [IDX_W-1:0]  index_q;
    logic [PIX_W-1:0]  current_sel;

    digit_scan_addr_gen #(
        .PIXELS     (PIXELS),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_addr_gen (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear      (clear),
        .advance    (advance),
        .compare    (compare),
        .pixel      (pixel),
        .digit      (digit),
        .ref_addr   (ref_addr),
        .last_pixel (last_pixel),
        .last_digit (last_digit)
    );

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and counter controls; start is only looked at in IDLE,
    // which is what makes a start during a scan a no-op.
    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        advance = 1'b0;
        compare = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                advance = 1'b1;
                if (last_pixel) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                compare = 1'b1;
                state_d = last_digit ? DONE : ACCUM;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Alignment stage: the memories answer one cycle after the address, so the
    // pair-valid flag, the digit index and the done pulse follow one cycle late.
    // Index only updates while scanning, so it changes on the first pair of a
    // new digit and otherwise holds.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            temp_q  <= 1'b0;
            done_q  <= 1'b0;
            index_q <= '0;
        end else begin
            temp_q <= (state_q == ACCUM);
            done_q <= (state_q == DONE);
            if ((state_q == ACCUM) || (state_q == COMPARE)) begin
                index_q <= digit;
            end
        end
    end

`ifdef DIGIT_SEQ_BINARIZE_EN
    assign current_sel = binarize(img_data, THRESH);
`else
    logic unused_thresh;
    assign unused_thresh = ^THRESH;
    assign current_sel   = img_data;
`endif

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign temp      = temp_q;
    assign index     = index_q;
    assign img_addr  = pixel;
    assign current   = temp_q ? current_sel : '0;
    assign reference = temp_q ? ref_data : '0;

endmodule
